// File: rtl/simon_round_engine.sv
// simon_round_engine: iterative Simon 128/128 encryption core between the ingress
// and egress FIFOs. It holds one block at a time and expands the key on the fly.
// Build option: define SIMON_ROUND_UNROLL2_EN to run two rounds and two key-schedule
// steps per cycle. Function and ports are identical in both builds.
module simon_round_engine #(
    parameter int unsigned DATA_DATA_WIDTH = 128,
    parameter int unsigned ROUNDS          = 68
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_DATA_WIDTH-1:0] key,
    input  logic [DATA_DATA_WIDTH-1:0] ingress_fifo_dout,
    input  logic                       ingress_fifo_vld,
    output logic                       ingress_fifo_rdy,
    output logic [DATA_DATA_WIDTH-1:0] egress_fifo_din,
    output logic                       egress_fifo_vld,
    input  logic                       egress_fifo_rdy,
    output logic                       busy
);

    localparam int unsigned HALF_W = DATA_DATA_WIDTH / 2;
    localparam int unsigned RCNT_W = 7;
    localparam int unsigned Z2_LEN = 62;
    // z2 sequence with bit j (LSB first) used at key step j
    localparam logic [63:0] Z2_SEQ = 64'h7369_f885_192c_0ef5;
`ifdef SIMON_ROUND_UNROLL2_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif
    localparam logic [RCNT_W-1:0] LAST_RCNT = RCNT_W'(ROUNDS - STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input int unsigned n);
        return (v << n) | (v >> (HALF_W - n));
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (HALF_W - n));
    endfunction

    // One Feistel round: new x half; the new y half is simply the old x
    function automatic logic [HALF_W-1:0] round_x(input logic [HALF_W-1:0] x,
                                                  input logic [HALF_W-1:0] y,
                                                  input logic [HALF_W-1:0] k);
        return y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k;
    endfunction

    // Key schedule step for m=2; ~ka ^ 3 folds in the constant c = 2^64-4
    function automatic logic [HALF_W-1:0] key_next(input logic [HALF_W-1:0] ka,
                                                   input logic [HALF_W-1:0] kb,
                                                   input logic              zb);
        logic [HALF_W-1:0] t;
        t = rotr(kb, 3) ^ rotr(kb, 4);
        return ~ka ^ t ^ HALF_W'(zb) ^ HALF_W'(3);
    endfunction

    // z2 bit for a round index in 0..ROUNDS, wrapping at the 62-bit period
    function automatic logic z2_bit(input logic [RCNT_W-1:0] r);
        logic [RCNT_W-1:0] idx;
        idx = (r >= RCNT_W'(Z2_LEN)) ? (r - RCNT_W'(Z2_LEN)) : r;
        return Z2_SEQ[6'(idx)];
    endfunction

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   x_q, x_d;
    logic [HALF_W-1:0]   y_q, y_d;
    logic [HALF_W-1:0]   ka_q, ka_d;
    logic [HALF_W-1:0]   kb_q, kb_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                rdy_q, rdy_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;

    logic [HALF_W-1:0]   x1_c, y1_c, ka1_c, kb1_c;
    logic [HALF_W-1:0]   xr_c, yr_c, kar_c, kbr_c;

    // First round stage and key step from the current state
    always_comb begin
        x1_c  = round_x(x_q, y_q, ka_q);
        y1_c  = x_q;
        ka1_c = kb_q;
        kb1_c = key_next(ka_q, kb_q, z2_bit(rcnt_q));
    end

`ifdef SIMON_ROUND_UNROLL2_EN
    logic [HALF_W-1:0]   x2_c, y2_c, ka2_c, kb2_c;

    // Second round stage chained behind the first, using the z2 bit for rcnt+1
    always_comb begin
        x2_c  = round_x(x1_c, y1_c, ka1_c);
        y2_c  = x1_c;
        ka2_c = kb1_c;
        kb2_c = key_next(ka1_c, kb1_c, z2_bit(rcnt_q + RCNT_W'(1)));
    end

    // Per-cycle result is the output of the second stage
    always_comb begin
        xr_c  = x2_c;
        yr_c  = y2_c;
        kar_c = ka2_c;
        kbr_c = kb2_c;
    end
`else
    // Per-cycle result is the output of the single stage
    always_comb begin
        xr_c  = x1_c;
        yr_c  = y1_c;
        kar_c = ka1_c;
        kbr_c = kb1_c;
    end
`endif

    // Next-state and next-output logic for the IDLE/ROUND/DONE controller
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ka_d    = ka_q;
        kb_d    = kb_q;
        rcnt_d  = rcnt_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ingress_fifo_vld && rdy_q) begin
                    x_d     = ingress_fifo_dout[DATA_DATA_WIDTH-1:HALF_W];
                    y_d     = ingress_fifo_dout[HALF_W-1:0];
                    ka_d    = key[HALF_W-1:0];
                    kb_d    = key[DATA_DATA_WIDTH-1:HALF_W];
                    rcnt_d  = '0;
                    state_d = ST_ROUND;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_ROUND: begin
                x_d    = xr_c;
                y_d    = yr_c;
                ka_d   = kar_c;
                kb_d   = kbr_c;
                rcnt_d = rcnt_q + RCNT_W'(STEP);
                if (rcnt_q == LAST_RCNT) begin
                    state_d = ST_DONE;
                    vld_d   = 1'b1;
                end
            end
            ST_DONE: begin
                if (egress_fifo_rdy) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ka_q    <= '0;
            kb_q    <= '0;
            rcnt_q  <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            rcnt_q  <= rcnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign ingress_fifo_rdy = rdy_q;
    assign egress_fifo_vld  = vld_q;
    assign egress_fifo_din  = {x_q, y_q};
    assign busy             = busy_q;

endmodule

// File: doc/simon_round_engine.md
# simon_round_engine

Iterative Simon 128/128 encryption core that sits between the AXI-to-FIFO bridge's ingress and egress FIFOs. It pops one 128-bit plaintext block from the ingress FIFO and runs the 68 Feistel rounds with on-the-fly key expansion. It then pushes the 128-bit ciphertext into the egress FIFO. Only one block is in flight at a time.

## Interface
Parameters:
- DATA_DATA_WIDTH, 128, block width; only 128 is supported.
- ROUNDS, 68, Simon 128/128 round count; fixed.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high.
- key  in  128  cipher key; key[63:0]=k0, key[127:64]=k1; sampled only on the accept edge.
- ingress_fifo_dout  in  128  plaintext; [127:64]=x, [63:0]=y.
- ingress_fifo_vld  in  1  plaintext available.
- ingress_fifo_rdy  out  1  engine accepts a block.
- egress_fifo_din  out  128  ciphertext; [127:64]=x, [63:0]=y.
- egress_fifo_vld  out  1  ciphertext valid.
- egress_fifo_rdy  in  1  egress FIFO not full.
- busy  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - ingress_fifo_rdy=1.
  - On ingress_fifo_vld&rdy, load x, y from ingress_fifo_dout and ka=k0, kb=k1 from key.
  - Clear rcnt (7-bit), then go to ROUND.
- ROUND, one round per cycle:
  - x' = y ^ ((x<<<1) & (x<<<8)) ^ (x<<<2) ^ ka; y' = x.
  - Key step: t = (kb>>>3) ^ (kb>>>4); knew = ~ka ^ t ^ z2[rcnt mod 62] ^ 64'h3 (the ~ flips all bits; the 0x3 term is carried over from the Simon constant c=2^64−4, ~ka ^ 3 = ka ^ c); ka' = kb; kb' = knew.
  - rcnt increments each cycle. When rcnt==ROUNDS-1, the last round is applied and the FSM goes to DONE.
- DONE:
  - egress_fifo_vld=1 and egress_fifo_din={x,y}, both held stable.
  - On egress_fifo_vld&rdy, go to IDLE.
- All rotates are 64-bit circular. z2 is the 62-bit Simon z2 sequence, bit j used at round j.
- ingress_fifo_rdy=0 in ROUND and DONE, so no new block is accepted until the egress handshake completes.
- The key port may change freely outside the accept edge; an in-flight block is unaffected.

## Timing
- Reset values:
  - ingress_fifo_rdy=1 (state IDLE), egress_fifo_vld=0, egress_fifo_din=0, busy=0.
  - Internal x, y, ka, kb, rcnt are all 0.
- Latency:
  - Accept edge at cycle 0; ROUND occupies edges 1..68.
  - egress_fifo_vld goes high after edge 68 and stays high until the handshake edge.
  - Minimum block period is 70 cycles (accept, 68 rounds, handshake), with egress_fifo_rdy held high.
- Backpressure: egress_fifo_rdy=0 in DONE holds state and data indefinitely; ingress stays blocked.
- Empty ingress: IDLE waits with rdy=1; a pulse of vld is taken on the edge it is seen.
- Reset asserted mid-ROUND or mid-DONE: the block is discarded, all outputs take their reset values immediately (asynchronous), and the FIFO pop/push already completed is not undone.
- A handshake edge in DONE and a new ingress vld cannot overlap, because rdy is low in DONE.

## Configuration
- SIMON_ROUND_UNROLL2_EN:
  - Defined: two rounds and two key-schedule steps per cycle.
    - The second stage uses the z2 bit for rcnt+1.
    - rcnt steps by 2 and ROUND exits when rcnt==ROUNDS-2, so ROUND lasts 34 cycles.
    - egress_fifo_vld rises after edge 34; block period is 36 cycles.
  - Undefined: one round per cycle as described above.
  - Function and ports are identical in both builds.

## Test plan
- Known answer: key=128'h0f0e0d0c0b0a0908_0706050403020100, plaintext 128'h6373656420737265_6c6c657661727420 -> egress_fifo_din=128'h49681b1e1e54fe3f_65aa832af84e0bbc, vld first high 68 cycles after accept (34 with SIMON_ROUND_UNROLL2_EN).
- Backpressure: hold egress_fifo_rdy=0 for 200 cycles after vld rises -> din unchanged, ingress_fifo_rdy=0 throughout, release -> one push, return to IDLE next cycle.
- Back-to-back: 4 blocks queued with rdy always high -> 4 correct ciphertexts in order, accept edges exactly 70 cycles apart (36 unrolled).
- Key change mid-block: switch key to all-zero on cycle 10 of ROUND -> ciphertext still matches the known-answer value for the original key.
- Reset at round 30: assert rst -> egress_fifo_vld=0, busy=0, ingress_fifo_rdy=1 immediately, no egress push. Then re-send the known-answer block -> correct ciphertext.
- All-zero key and plaintext -> output matches the golden software model; no X on any output after reset.
